// File: rtl/jtag_1149_d10_pkg.sv
// rtl/jtag_1149_d10_pkg.sv - shared K28.5 constants, symbol width and aligner state encoding
package jtag_1149_d10_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] K285_RDN = 10'b0011111010;
  localparam logic [SYM_W-1:0] K285_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } align_state_e;

  function automatic logic is_comma(input logic [SYM_W-1:0] sym);
    return (sym == K285_RDN) || (sym == K285_RDP);
  endfunction

endpackage

// File: rtl/jtag_1149_d10_mstr_rx_aligner_if.sv
// rtl/jtag_1149_d10_mstr_rx_aligner_if.sv - raw word input and aligned symbol output bundle
interface jtag_1149_d10_mstr_rx_aligner_if;
  import jtag_1149_d10_pkg::*;

  logic [SYM_W-1:0] raw_data;
  logic             raw_vld;
  logic             realign_req;
  logic [SYM_W-1:0] jtag_1149_d10_mstr_data_in;
  logic             aligned_vld;
  logic             align_lock;
  logic [3:0]       align_offset;
  logic             align_lost;

  // Aligner side: consumes raw words, produces framed symbols and status
  modport slave (
    input  raw_data, raw_vld, realign_req,
    output jtag_1149_d10_mstr_data_in, aligned_vld, align_lock, align_offset, align_lost
  );

  // Driver side: deserializer / Rx controller view
  modport master (
    output raw_data, raw_vld, realign_req,
    input  jtag_1149_d10_mstr_data_in, aligned_vld, align_lock, align_offset, align_lost
  );

endinterface

// File: rtl/jtag_1149_d10_comma_detect.sv
// rtl/jtag_1149_d10_comma_detect.sv - combinational K28.5 search over a 20-bit window
module jtag_1149_d10_comma_detect
  import jtag_1149_d10_pkg::*;
(
  input  logic [2*SYM_W-1:0] win_i,
  output logic               hit_o,
  output logic [3:0]         hit_k_o
);

  // Scan from the highest offset down so the lowest matching offset is left standing
  always_comb begin
    hit_o   = 1'b0;
    hit_k_o = 4'd0;
    for (int k = SYM_W - 1; k >= 0; k--) begin
      if (is_comma(win_i[2*SYM_W-1-k -: SYM_W])) begin
        hit_o   = 1'b1;
        hit_k_o = 4'(k);
      end
    end
  end

endmodule

// File: rtl/jtag_1149_d10_mstr_rx_aligner.sv
// rtl/jtag_1149_d10_mstr_rx_aligner.sv - comma word aligner; JTAG_1149_D10_RX_ALIGN_STATS_EN adds loss/slip counters
module jtag_1149_d10_mstr_rx_aligner
  import jtag_1149_d10_pkg::*;
#(
  parameter int                      ENC_DATA_WIDTH = 10,
  parameter int                      LOCK_CNT       = 3,
  parameter int                      LOSS_CNT       = 4,
  parameter int                      CNT_WIDTH      = 3,
  parameter logic [ENC_DATA_WIDTH-1:0] IDLE_SYM     = 10'b0011111010
) (
  input  logic clk_i,
  input  logic rst_i,
  jtag_1149_d10_mstr_rx_aligner_if.slave bus
`ifdef JTAG_1149_D10_RX_ALIGN_STATS_EN
  ,
  output logic [15:0] align_loss_cnt_o,
  output logic [15:0] align_slip_cnt_o
`endif
);

  localparam logic [CNT_WIDTH-1:0] LOCK_TGT = CNT_WIDTH'(LOCK_CNT);
  localparam logic [CNT_WIDTH-1:0] LOSS_TGT = CNT_WIDTH'(LOSS_CNT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};

  align_state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]        vcnt_q, vcnt_d, lcnt_q, lcnt_d;
  logic [CNT_WIDTH-1:0]        vcnt_inc, lcnt_inc;
  logic [3:0]                  cand_off_q, cand_off_d;
  logic [3:0]                  lock_off_q, lock_off_d;
  logic                        lost_q, lost_d;
  logic [ENC_DATA_WIDTH-1:0]   prev_word_q;
  logic [ENC_DATA_WIDTH-1:0]   data_q, data_d;
  logic                        avld_q, avld_d;
  logic [2*ENC_DATA_WIDTH-1:0] window;
  logic [ENC_DATA_WIDTH-1:0]   cand_sel;
  logic                        det_hit, hit;
  logic [3:0]                  det_k;

  assign window = {prev_word_q, bus.raw_data};
  assign hit    = bus.raw_vld & det_hit;

  jtag_1149_d10_comma_detect u_comma_detect (
    .win_i   (window),
    .hit_o   (det_hit),
    .hit_k_o (det_k)
  );

  // Counters stop at all-ones instead of wrapping
  assign vcnt_inc = (vcnt_q == CNT_MAX) ? vcnt_q : vcnt_q + CNT_ONE;
  assign lcnt_inc = (lcnt_q == CNT_MAX) ? lcnt_q : lcnt_q + CNT_ONE;

  // Pick the window slice at the locked offset
  always_comb begin
    cand_sel = '0;
    for (int k = 0; k < ENC_DATA_WIDTH; k++) begin
      if (lock_off_q == 4'(k)) cand_sel = window[2*ENC_DATA_WIDTH-1-k -: ENC_DATA_WIDTH];
    end
  end

  // State register, counters, offsets and the previous raw word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_HUNT;
      vcnt_q      <= '0;
      lcnt_q      <= '0;
      cand_off_q  <= 4'd0;
      lock_off_q  <= 4'd0;
      lost_q      <= 1'b0;
      prev_word_q <= '0;
    end else begin
      state_q    <= state_d;
      vcnt_q     <= vcnt_d;
      lcnt_q     <= lcnt_d;
      cand_off_q <= cand_off_d;
      lock_off_q <= lock_off_d;
      lost_q     <= lost_d;
      if (bus.raw_vld) prev_word_q <= bus.raw_data;
    end
  end

  // Next-state: realign wins, otherwise only a valid comma moves the FSM
  always_comb begin
    state_d    = state_q;
    vcnt_d     = vcnt_q;
    lcnt_d     = lcnt_q;
    cand_off_d = cand_off_q;
    lock_off_d = lock_off_q;
    lost_d     = 1'b0;
    if (bus.realign_req) begin
      state_d = ST_HUNT;
      vcnt_d  = '0;
      lcnt_d  = '0;
    end else if (hit) begin
      unique case (state_q)
        ST_HUNT: begin
          cand_off_d = det_k;
          vcnt_d     = CNT_ONE;
          if (CNT_ONE >= LOCK_TGT) begin
            state_d    = ST_LOCKED;
            lock_off_d = det_k;
            lcnt_d     = '0;
          end else begin
            state_d = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (det_k == cand_off_q) begin
            vcnt_d = vcnt_inc;
            if (vcnt_inc >= LOCK_TGT) begin
              state_d    = ST_LOCKED;
              lock_off_d = cand_off_q;
              lcnt_d     = '0;
            end
          end else begin
            cand_off_d = det_k;
            vcnt_d     = CNT_ONE;
          end
        end
        ST_LOCKED: begin
          if (det_k == lock_off_q) begin
            lcnt_d = '0;
          end else begin
            lcnt_d = lcnt_inc;
            if (lcnt_inc >= LOSS_TGT) begin
              state_d = ST_HUNT;
              lost_d  = 1'b1;
              vcnt_d  = '0;
              lcnt_d  = '0;
            end
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Output mux: framed symbol while locked, idle comma otherwise
  always_comb begin
    data_d = data_q;
    avld_d = 1'b0;
    if (state_q == ST_LOCKED) begin
      if (bus.raw_vld) begin
        data_d = cand_sel;
        avld_d = 1'b1;
      end
    end else begin
      data_d = IDLE_SYM;
    end
  end

  // Output register, one cycle behind the window
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q <= IDLE_SYM;
      avld_q <= 1'b0;
    end else begin
      data_q <= data_d;
      avld_q <= avld_d;
    end
  end

  assign bus.jtag_1149_d10_mstr_data_in = data_q;
  assign bus.aligned_vld                = avld_q;
  assign bus.align_lock                 = (state_q == ST_LOCKED);
  assign bus.align_offset               = lock_off_q;
  assign bus.align_lost                 = lost_q;

`ifdef JTAG_1149_D10_RX_ALIGN_STATS_EN
  logic [15:0] loss_cnt_q, slip_cnt_q;
  logic        slip_evt;

  assign slip_evt = (state_q == ST_LOCKED) && hit && (det_k != lock_off_q);

  // Saturating loss and slip statistics, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      loss_cnt_q <= 16'd0;
      slip_cnt_q <= 16'd0;
    end else begin
      if (lost_d && (loss_cnt_q != 16'hFFFF)) loss_cnt_q <= loss_cnt_q + 16'd1;
      if (slip_evt && (slip_cnt_q != 16'hFFFF)) slip_cnt_q <= slip_cnt_q + 16'd1;
    end
  end

  assign align_loss_cnt_o = loss_cnt_q;
  assign align_slip_cnt_o = slip_cnt_q;
`endif

endmodule

// File: tb/tb_jtag_1149_d10_mstr_rx_aligner.sv
// tb/tb_jtag_1149_d10_mstr_rx_aligner.sv - directed bench for the comma word aligner
module tb_jtag_1149_d10_mstr_rx_aligner;

  localparam logic [9:0] K   = 10'h0FA;
  localparam logic [9:0] IDL = 10'h0FA;

  localparam logic [9:0] T2  [11] = '{K, 10'h2AA, K, 10'h155, K, 10'h333, 10'h2AA, 10'h0CC, 10'h155, 10'h2AA, 10'h155};
  localparam logic [9:0] T3A [4]  = '{K, 10'h2AA, K, 10'h155};
  localparam logic [9:0] T3B [8]  = '{K, 10'h2AA, K, 10'h0CC, K, 10'h333, 10'h2AA, 10'h155};
  localparam logic [9:0] T4A [6]  = '{K, 10'h2AA, K, 10'h155, K, 10'h0CC};
  localparam logic [9:0] T4B [4]  = '{K, 10'h2AA, K, 10'h155};
  localparam logic [9:0] T4C [2]  = '{K, 10'h2AA};
  localparam logic [9:0] T4D [18] = '{K, 10'h155, K, 10'h2AA, K, 10'h155, K, 10'h2AA, K, 10'h155,
                                      K, 10'h2AA, K, 10'h333, 10'h0CC, 10'h155, 10'h2AA, 10'h155};

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  bit   sq[$];

  always #5 clk = ~clk;

  jtag_1149_d10_mstr_rx_aligner_if bus ();

`ifdef JTAG_1149_D10_RX_ALIGN_STATS_EN
  logic [15:0] loss_cnt, slip_cnt;
`endif

  jtag_1149_d10_mstr_rx_aligner dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef JTAG_1149_D10_RX_ALIGN_STATS_EN
    ,
    .align_loss_cnt_o (loss_cnt),
    .align_slip_cnt_o (slip_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic [9:0] d, input logic v, input logic rr);
    bus.raw_data    = d;
    bus.raw_vld     = v;
    bus.realign_req = rr;
    @(posedge clk);
    #1;
    bus.realign_req = 1'b0;
  endtask

  task automatic push_bits(input logic [9:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) sq.push_back(v[i]);
  endtask

  task automatic send_word(input logic rr);
    logic [9:0] w;
    for (int i = 9; i >= 0; i--) w[i] = (sq.size() > 0) ? sq.pop_front() : 1'b0;
    cyc(w, 1'b1, rr);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(10'h000, 1'b0, 1'b0);
    rst = 1'b0;
    sq.delete();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"}, 16'(bus.jtag_1149_d10_mstr_data_in), 16'(IDL));
    chk({tag, "_vld"},  16'(bus.aligned_vld), 16'd0);
    chk({tag, "_lock"}, 16'(bus.align_lock), 16'd0);
    chk({tag, "_off"},  16'(bus.align_offset), 16'd0);
    chk({tag, "_lost"}, 16'(bus.align_lost), 16'd0);
  endtask

  initial begin
    rst             = 1'b1;
    bus.raw_data    = '0;
    bus.raw_vld     = 1'b0;
    bus.realign_req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst = 1'b0;

    // Offset-0 commas: first hit needs a previous word, so lock lands on word 4
    for (int n = 0; n < 5; n++) begin
      cyc(K, 1'b1, 1'b0);
      if (n == 2) chk("t1_lock_early", 16'(bus.align_lock), 16'd0);
      if (n == 3) begin
        chk("t1_lock", 16'(bus.align_lock), 16'd1);
        chk("t1_off",  16'(bus.align_offset), 16'd0);
        chk("t1_vld0", 16'(bus.aligned_vld), 16'd0);
      end
      if (n == 4) begin
        chk("t1_vld",  16'(bus.aligned_vld), 16'd1);
        chk("t1_data", 16'(bus.jtag_1149_d10_mstr_data_in), 16'(K));
      end
    end
    cyc(K, 1'b1, 1'b1);
    chk("t1_rr_lock", 16'(bus.align_lock), 16'd0);
    chk("t1_rr_lost", 16'(bus.align_lost), 16'd0);
    cyc(10'h000, 1'b0, 1'b0);
    chk("t1_rr_vld", 16'(bus.aligned_vld), 16'd0);

    // Serial stream delayed by 3 bits
    do_reset();
    push_bits(10'b101, 3);
    foreach (T2[i]) push_bits(T2[i], 10);
    for (int n = 0; n < 10; n++) begin
      send_word(1'b0);
      if (n == 4) chk("t2_lock_early", 16'(bus.align_lock), 16'd0);
      if (n == 5) begin
        chk("t2_lock", 16'(bus.align_lock), 16'd1);
        chk("t2_off",  16'(bus.align_offset), 16'd3);
      end
      if (n >= 6) begin
        chk("t2_data", 16'(bus.jtag_1149_d10_mstr_data_in), 16'(T2[n-1]));
        chk("t2_vld",  16'(bus.aligned_vld), 16'd1);
      end
    end

    // Two commas at offset 3 then three at offset 5
    do_reset();
    push_bits(10'b101, 3);
    foreach (T3A[i]) push_bits(T3A[i], 10);
    push_bits(10'b01, 2);
    foreach (T3B[i]) push_bits(T3B[i], 10);
    for (int n = 0; n < 11; n++) begin
      send_word(1'b0);
      chk("t3_lock", 16'(bus.align_lock), 16'(n >= 9));
      if (n == 9) chk("t3_off", 16'(bus.align_offset), 16'd5);
      if (n == 10) begin
        chk("t3_data", 16'(bus.jtag_1149_d10_mstr_data_in), 16'h333);
        chk("t3_vld",  16'(bus.aligned_vld), 16'd1);
      end
    end

    // Lock at 2, slips at 7 interrupted by one good comma, then loss and relock at 7
    do_reset();
    push_bits(10'b01, 2);
    foreach (T4A[i]) push_bits(T4A[i], 10);
    push_bits(10'b01010, 5);
    foreach (T4B[i]) push_bits(T4B[i], 10);
    push_bits(10'b01010, 5);
    foreach (T4C[i]) push_bits(T4C[i], 10);
    push_bits(10'b01010, 5);
    foreach (T4D[i]) push_bits(T4D[i], 10);
    for (int n = 0; n < 28; n++) begin
      send_word(1'b0);
      chk("t4_lost", 16'(bus.align_lost), 16'(n == 20));
      chk("t4_lock", 16'(bus.align_lock), 16'(((n >= 5) && (n < 20)) || (n >= 26)));
      if (n == 5)  chk("t4_off2", 16'(bus.align_offset), 16'd2);
      if (n == 6)  chk("t4_data_a", 16'(bus.jtag_1149_d10_mstr_data_in), 16'h0CC);
      if (n == 13) chk("t4_data_b", 16'(bus.jtag_1149_d10_mstr_data_in), 16'h2AA);
      if (n == 21) begin
        chk("t4_idle", 16'(bus.jtag_1149_d10_mstr_data_in), 16'(IDL));
        chk("t4_idle_vld", 16'(bus.aligned_vld), 16'd0);
      end
      if (n == 26) chk("t4_off7", 16'(bus.align_offset), 16'd7);
      if (n == 27) begin
        chk("t4_data_c", 16'(bus.jtag_1149_d10_mstr_data_in), 16'h333);
        chk("t4_vld_c",  16'(bus.aligned_vld), 16'd1);
      end
    end
`ifdef JTAG_1149_D10_RX_ALIGN_STATS_EN
    chk("stats_loss", loss_cnt, 16'd1);
    chk("stats_slip", slip_cnt, 16'd6);
`endif

    // Idle gap while locked, then resume and realign
    repeat (5) cyc(10'h3FF, 1'b0, 1'b0);
    chk("gap_lock", 16'(bus.align_lock), 16'd1);
    chk("gap_off",  16'(bus.align_offset), 16'd7);
    chk("gap_vld",  16'(bus.aligned_vld), 16'd0);
    chk("gap_data", 16'(bus.jtag_1149_d10_mstr_data_in), 16'h333);
    send_word(1'b0);
    chk("gap_resume", 16'(bus.jtag_1149_d10_mstr_data_in), 16'h0CC);
    send_word(1'b1);
    chk("t5_rr_lock", 16'(bus.align_lock), 16'd0);
    chk("t5_rr_lost", 16'(bus.align_lost), 16'd0);

    // Reset while in VERIFY
    do_reset();
    cyc(K, 1'b1, 1'b0);
    cyc(K, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(K, 1'b1, 1'b0);
    chk_reset_outputs("t6");
`ifdef JTAG_1149_D10_RX_ALIGN_STATS_EN
    chk("t6_stats_loss", loss_cnt, 16'd0);
`endif
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      cyc(K, 1'b1, 1'b0);
      if (n == 2) chk("t6_lock_early", 16'(bus.align_lock), 16'd0);
      if (n == 3) chk("t6_lock", 16'(bus.align_lock), 16'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
